exe_stage: RTL

- Execute stage of the 5-stage ARM-subset pipeline. Consumes the decoded fields registered at the ID/EXE boundary.
- Builds operand 2 (Val2), runs the ALU, computes the branch target and owns the NZCV status register.
- Registers all results into an internal EXE/MEM boundary register, which feeds the memory stage.

---
 rtl/exe_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: builds operand 2, runs the ALU, computes the branch target,
// owns the NZCV status register and registers results at the EXE/MEM boundary.
module exe_stage #(
  parameter int unsigned LEN_ADDRESS     = 32,
  parameter int unsigned LEN_REGISTER    = 32,
  parameter int unsigned LEN_REG_ADDRESS = 4,
  parameter int unsigned LEN_STATUS      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic [LEN_ADDRESS-1:0]     pc_in,
  input  logic [LEN_STATUS-1:0]      status_reg_in,
  input  logic [LEN_REGISTER-1:0]    reg_file_out1_in,
  input  logic [LEN_REGISTER-1:0]    reg_file_out2_in,
  input  logic [23:0]                signed_immediate_in,
  input  logic [11:0]                shift_operand_in,
  input  logic                       is_immediate_in,
  input  logic                       status_write_enable_in,
  input  logic [3:0]                 execute_command_in,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic                       wb_enable_in,
  input  logic                       is_branch_in,
  input  logic [LEN_REG_ADDRESS-1:0] dest_reg_in,
  output logic                       branch_taken_out,
  output logic [LEN_ADDRESS-1:0]     branch_address_out,
  output logic [LEN_STATUS-1:0]      status_out,
  output logic [LEN_REGISTER-1:0]    alu_result_out,
  output logic [LEN_REGISTER-1:0]    store_value_out,
  output logic [LEN_REG_ADDRESS-1:0] dest_reg_out,
  output logic                       mem_read_out,
  output logic                       mem_write_out,
  output logic                       wb_enable_out
);

  localparam int unsigned SHW = $clog2(LEN_REGISTER) + 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [LEN_REGISTER-1:0]    w_imm_ext;
  logic [SHW-1:0]             w_imm_rot;
  logic [SHW-1:0]             w_imm_rot_inv;
  logic [LEN_REGISTER-1:0]    w_imm_val;
  logic [SHW-1:0]             w_sh_amt;
  logic [SHW-1:0]             w_sh_amt_inv;
  logic [LEN_REGISTER-1:0]    w_rm;
  logic [LEN_REGISTER-1:0]    w_rm_shifted;
  logic [LEN_REGISTER-1:0]    w_val2;

  logic [LEN_REGISTER-1:0]    w_a;
  logic                       w_cin;
  logic [LEN_REGISTER:0]      w_sum;
  logic [LEN_REGISTER:0]      w_diff;
  logic [LEN_REGISTER-1:0]    w_result;
  logic                       w_flag_c;
  logic                       w_flag_v;
  logic [LEN_STATUS-1:0]      w_status_next;
  logic [LEN_ADDRESS-1:0]     w_simm_ext;
  logic                       w_unused_status;

  logic [LEN_STATUS-1:0]      r_status;
  logic [LEN_REGISTER-1:0]    r_alu_result;
  logic [LEN_REGISTER-1:0]    r_store_value;
  logic [LEN_REG_ADDRESS-1:0] r_dest_reg;
  logic                       r_mem_read;
  logic                       r_mem_write;
  logic                       r_wb_enable;

  assign w_a             = reg_file_out1_in;
  assign w_rm            = reg_file_out2_in;
  assign w_cin           = status_reg_in[1];
  assign w_unused_status = &{1'b0, status_reg_in[3:2]};

  // Rotate-immediate and register-shift paths; a zero amount leaves the value intact
  assign w_imm_ext     = LEN_REGISTER'(shift_operand_in[7:0]);
  assign w_imm_rot     = SHW'({shift_operand_in[11:8], 1'b0});
  assign w_imm_rot_inv = SHW'(LEN_REGISTER) - w_imm_rot;
  assign w_imm_val     = (w_imm_ext >> w_imm_rot) | (w_imm_ext << w_imm_rot_inv);
  assign w_sh_amt      = SHW'(shift_operand_in[11:7]);
  assign w_sh_amt_inv  = SHW'(LEN_REGISTER) - w_sh_amt;

  always_comb begin
    w_rm_shifted = w_rm;
    unique case (shift_operand_in[6:5])
      2'b00:   w_rm_shifted = w_rm << w_sh_amt;
      2'b01:   w_rm_shifted = w_rm >> w_sh_amt;
      2'b10:   w_rm_shifted = LEN_REGISTER'($signed(w_rm) >>> w_sh_amt);
      default: w_rm_shifted = (w_rm >> w_sh_amt) | (w_rm << w_sh_amt_inv);
    endcase
  end

  // Memory accesses use the raw 12-bit offset, ahead of both shifter paths
  always_comb begin
    w_val2 = w_rm_shifted;
    if (mem_read_in || mem_write_in)
      w_val2 = LEN_REGISTER'(shift_operand_in);
    else if (is_immediate_in)
      w_val2 = w_imm_val;
  end

  // Subtract borrow is ~Cin only for SBC
  assign w_sum  = {1'b0, w_a} + {1'b0, w_val2}
                + (LEN_REGISTER+1)'((execute_command_in == CMD_ADC) && w_cin);
  assign w_diff = {1'b0, w_a} - {1'b0, w_val2}
                - (LEN_REGISTER+1)'((execute_command_in == CMD_SBC) && !w_cin);

  always_comb begin
    w_result = '0;
    w_flag_c = status_reg_in[1];
    w_flag_v = status_reg_in[0];
    unique case (execute_command_in)
      CMD_MOV: w_result = w_val2;
      CMD_MVN: w_result = ~w_val2;
      CMD_AND: w_result = w_a & w_val2;
      CMD_ORR: w_result = w_a | w_val2;
      CMD_EOR: w_result = w_a ^ w_val2;
      CMD_ADD, CMD_ADC: begin
        w_result = w_sum[LEN_REGISTER-1:0];
        w_flag_c = w_sum[LEN_REGISTER];
        w_flag_v = (w_a[LEN_REGISTER-1] == w_val2[LEN_REGISTER-1]) &&
                   (w_sum[LEN_REGISTER-1] != w_a[LEN_REGISTER-1]);
      end
      CMD_SUB, CMD_SBC: begin
        w_result = w_diff[LEN_REGISTER-1:0];
        w_flag_c = ~w_diff[LEN_REGISTER];
        w_flag_v = (w_a[LEN_REGISTER-1] != w_val2[LEN_REGISTER-1]) &&
                   (w_diff[LEN_REGISTER-1] != w_a[LEN_REGISTER-1]);
      end
      default: begin
        w_result = '0;
        w_flag_c = 1'b0;
        w_flag_v = 1'b0;
      end
    endcase
  end

  assign w_status_next = {w_result[LEN_REGISTER-1], (w_result == '0), w_flag_c, w_flag_v};

  // Branch target: word offset sign-extended and scaled to bytes
  assign w_simm_ext         = LEN_ADDRESS'($signed(signed_immediate_in));
  assign branch_address_out = pc_in + (w_simm_ext << 2);
  assign branch_taken_out   = is_branch_in;

  always_ff @(posedge clk) begin
    if (!rst)
      r_status <= '0;
    else if (!freeze && status_write_enable_in)
      r_status <= w_status_next;
  end

  // EXE/MEM boundary; a branch never writes back or touches memory
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alu_result  <= '0;
      r_store_value <= '0;
      r_dest_reg    <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_wb_enable   <= 1'b0;
    end else if (!freeze) begin
      r_alu_result  <= w_result;
      r_store_value <= reg_file_out2_in;
      r_dest_reg    <= dest_reg_in;
      r_mem_read    <= mem_read_in  && !is_branch_in;
      r_mem_write   <= mem_write_in && !is_branch_in;
      r_wb_enable   <= wb_enable_in && !is_branch_in;
    end
  end

  assign status_out      = r_status;
  assign alu_result_out  = r_alu_result;
  assign store_value_out = r_store_value;
  assign dest_reg_out    = r_dest_reg;
  assign mem_read_out    = r_mem_read;
  assign mem_write_out   = r_mem_write;
  assign wb_enable_out   = r_wb_enable;

endmodule
